// File: rtl/posit_pio_bridge_pkg.sv
// Shared types and defaults for the posit PIO bridge.
// Holds the FSM state enum and the NaR pattern helper.
package posit_pio_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ISSUE,
    WAIT
  } state_e;

  localparam int DEF_NBITS          = 32;
  localparam int DEF_SETTLE_CYCLES  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  // NaR is the sign bit alone; callers truncate to their width
  function automatic logic [63:0] nar_word(input int unsigned nbits);
    nar_word = 64'd1 << (nbits - 1);
  endfunction

endpackage

// File: rtl/posit_pio_down_counter.sv
// Loadable down counter with a zero flag.
// Load has priority over decrement; decrement stops at zero.
module posit_pio_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/posit_pio_bridge.sv
// Bridges HPS PIO operand exports to a posit core request/response port.
// Operands must hold still before a request is issued.
module posit_pio_bridge
  import posit_pio_bridge_pkg::*;
#(
  parameter int NBITS          = DEF_NBITS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] num1,
  input  logic [NBITS-1:0] num2,
  output logic [NBITS-1:0] result,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [NBITS-1:0] req_num1,
  output logic [NBITS-1:0] req_num2,
  input  logic             resp_valid,
  input  logic [NBITS-1:0] resp_result,
  output logic             busy,
  output logic [15:0]      done_count,
  output logic             timeout_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NBITS-1:0] NAR = NBITS'(nar_word(NBITS));

  state_e           state_q, state_d;
  logic [NBITS-1:0] snap1_q, snap1_d;
  logic [NBITS-1:0] snap2_q, snap2_d;
  logic [NBITS-1:0] last1_q, last1_d;
  logic [NBITS-1:0] last2_q, last2_d;
  logic [NBITS-1:0] result_q, result_d;
  logic [15:0]      done_q, done_d;
  logic             err_q, err_d;

  logic s_load, s_dec, s_zero;
  logic t_load, t_dec, t_zero;
  logic diff_last, diff_snap;

  assign diff_last = {num1, num2} != {last1_q, last2_q};
  assign diff_snap = {num1, num2} != {snap1_q, snap2_q};

  posit_pio_down_counter #(.W(SW)) u_settle (
    .clk      (clock),
    .reset    (reset),
    .load     (s_load),
    .dec      (s_dec),
    .load_val (SW'(SETTLE_CYCLES - 1)),
    .zero     (s_zero)
  );

  posit_pio_down_counter #(.W(TW)) u_timeout (
    .clk      (clock),
    .reset    (reset),
    .load     (t_load),
    .dec      (t_dec),
    .load_val (TW'(TIMEOUT_CYCLES - 1)),
    .zero     (t_zero)
  );

  always_comb begin
    state_d  = state_q;
    snap1_d  = snap1_q;
    snap2_d  = snap2_q;
    last1_d  = last1_q;
    last2_d  = last2_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    s_load   = 1'b0;
    s_dec    = 1'b0;
    t_load   = 1'b0;
    t_dec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (diff_last) begin
          snap1_d = num1;
          snap2_d = num2;
          s_load  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (diff_snap) begin
          snap1_d = num1;
          snap2_d = num2;
          s_load  = 1'b1;
        end else if (s_zero) begin
          state_d = ISSUE;
        end else begin
          s_dec = 1'b1;
        end
      end
      ISSUE: begin
        if (req_ready) begin
          last1_d = snap1_q;
          last2_d = snap2_q;
          t_load  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // a response arriving on the timeout cycle still counts
        if (resp_valid) begin
          result_d = resp_result;
          done_d   = done_q + 16'd1;
          state_d  = IDLE;
        end else if (t_zero) begin
          result_d = NAR;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          t_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      snap1_q  <= '0;
      snap2_q  <= '0;
      last1_q  <= '0;
      last2_q  <= '0;
      result_q <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap1_q  <= snap1_d;
      snap2_q  <= snap2_d;
      last1_q  <= last1_d;
      last2_q  <= last2_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign result      = result_q;
  assign req_valid   = (state_q == ISSUE);
  assign req_num1    = snap1_q;
  assign req_num2    = snap2_q;
  assign busy        = (state_q != IDLE);
  assign done_count  = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_posit_pio_bridge.sv
// Bench for posit_pio_bridge: directed scenarios plus random traffic,
// all cycles checked against a transaction-level model.
module tb_posit_pio_bridge;

  localparam int S = 4;
  localparam int T = 1024;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] num1, num2;
  logic [31:0] result, req_num1, req_num2, resp_result;
  logic        req_valid, req_ready, resp_valid, busy, timeout_err;
  logic [15:0] done_count;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  always #5 clock = ~clock;

  posit_pio_bridge dut (
    .clock       (clock),
    .reset       (reset),
    .num1        (num1),
    .num2        (num2),
    .result      (result),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_num1    (req_num1),
    .req_num2    (req_num2),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .busy        (busy),
    .done_count  (done_count),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: idle -> hunting for a stable new pair -> requesting -> in flight
  typedef enum {M_IDLE, M_HUNT, M_REQ, M_FLIGHT} mmode_e;
  mmode_e      mm;
  logic [31:0] m_snap1, m_snap2, m_last1, m_last2, m_result;
  logic [15:0] m_done;
  logic        m_err;
  int          m_age, m_wait;

  always @(posedge clock) begin
    if (reset) begin
      mm <= M_IDLE;
      m_snap1 <= '0; m_snap2 <= '0;
      m_last1 <= '0; m_last2 <= '0;
      m_result <= '0; m_done <= '0; m_err <= 1'b0;
      m_age <= 0; m_wait <= 0;
    end else begin
      case (mm)
        M_IDLE: if ({num1, num2} != {m_last1, m_last2}) begin
          mm <= M_HUNT;
          m_snap1 <= num1; m_snap2 <= num2; m_age <= 1;
        end
        M_HUNT: if ({num1, num2} != {m_snap1, m_snap2}) begin
          m_snap1 <= num1; m_snap2 <= num2; m_age <= 1;
        end else if (m_age == S) begin
          mm <= M_REQ;
        end else begin
          m_age <= m_age + 1;
        end
        M_REQ: if (req_ready) begin
          mm <= M_FLIGHT;
          m_last1 <= m_snap1; m_last2 <= m_snap2; m_wait <= 0;
        end
        M_FLIGHT: if (resp_valid) begin
          mm <= M_IDLE;
          m_result <= resp_result;
          m_done <= m_done + 16'd1;
        end else if (m_wait == T - 1) begin
          mm <= M_IDLE;
          m_result <= 32'h8000_0000;
          m_err <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
        default: mm <= M_IDLE;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m_req_valid", 32'(req_valid), 32'(mm == M_REQ));
      chk("m_busy", 32'(busy), 32'(mm != M_IDLE));
      chk("m_req_num1", req_num1, m_snap1);
      chk("m_req_num2", req_num2, m_snap2);
      chk("m_result", result, m_result);
      chk("m_done", 32'(done_count), 32'(m_done));
      chk("m_err", 32'(timeout_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    num1 = '0; num2 = '0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_result = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_req(output int lat);
    lat = 0;
    while (!req_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic respond(input logic [31:0] r);
    resp_valid = 1'b1; resp_result = r;
    step();
    resp_valid = 1'b0;
  endtask

  int lat, n, cnt;
  logic [31:0] a, b;

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_result", result, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step(); step();
    chk("rst_zero_idle", 32'(busy), 32'h0);

    // basic operation
    num1 = 32'h4000_0000; num2 = 32'h4000_0000; req_ready = 1'b1;
    wait_req(lat);
    chk("t1_latency", lat, 5);
    step();
    req_ready = 1'b0;
    step(); step();
    respond(32'h4800_0000);
    step();
    chk("t1_result", result, 32'h4800_0000);
    chk("t1_done", 32'(done_count), 32'd1);
    chk("t1_busy", 32'(busy), 32'h0);

    // staggered operand change
    do_reset();
    num1 = 32'h1111_1111;
    step(); step();
    num2 = 32'h2222_2222;
    wait_req(lat);
    chk("t2_latency", lat, 5);
    chk("t2_num1", req_num1, 32'h1111_1111);
    chk("t2_num2", req_num2, 32'h2222_2222);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    respond(32'h1234_5678);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_valid) cnt++;
    end
    chk("t2_one_req", cnt, 0);

    // backpressure with churning operands
    do_reset();
    a = 32'h3A00_0001; b = 32'h5B00_0002;
    num1 = a; num2 = b;
    wait_req(lat);
    for (int i = 0; i < 10; i++) begin
      num1 = $urandom; num2 = $urandom;
      step();
      chk("t3_hold_valid", 32'(req_valid), 32'h1);
      chk("t3_hold_num1", req_num1, a);
      chk("t3_hold_num2", req_num2, b);
    end
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("t3_in_wait", 32'({busy, req_valid}), 32'b10);
    respond(32'h0BAD_F00D);
    chk("t3_result", result, 32'h0BAD_F00D);

    // timeout
    do_reset();
    num1 = 32'h1; num2 = 32'h2; req_ready = 1'b1;
    wait_req(lat);
    step();
    req_ready = 1'b0;
    n = 0;
    while (busy && n < 1100) begin
      step();
      n++;
    end
    chk("t4_wait_len", n, T);
    chk("t4_nar", result, 32'h8000_0000);
    chk("t4_err", 32'(timeout_err), 32'h1);
    chk("t4_done", 32'(done_count), 32'h0);
    num1 = 32'h3; req_ready = 1'b1;
    wait_req(lat);
    step();
    req_ready = 1'b0;
    respond(32'h7777_0000);
    chk("t4_err_sticky", 32'(timeout_err), 32'h1);
    chk("t4_done2", 32'(done_count), 32'h1);

    // operands change during WAIT
    do_reset();
    num1 = 32'h5; num2 = 32'h6; req_ready = 1'b1;
    wait_req(lat);
    step();
    req_ready = 1'b0;
    num1 = 32'h7; num2 = 32'h8;
    step(); step();
    respond(32'hAAAA_0001);
    chk("t5_first", result, 32'hAAAA_0001);
    req_ready = 1'b1;
    wait_req(lat);
    chk("t5_auto_num1", req_num1, 32'h7);
    chk("t5_auto_num2", req_num2, 32'h8);
    step();
    req_ready = 1'b0;
    respond(32'hBBBB_0002);
    chk("t5_second", result, 32'hBBBB_0002);
    chk("t5_done", 32'(done_count), 32'd2);

    // reset mid-flight then a stray response
    do_reset();
    num1 = 32'h9; num2 = 32'hA; req_ready = 1'b1;
    wait_req(lat);
    step();
    req_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    respond(32'hDEAD_BEEF);
    step();
    chk("t6_result", result, 32'h0);
    chk("t6_done", 32'(done_count), 32'h0);

    // random traffic
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) num1 = {$urandom_range(0, 3), 30'h0};
      if ($urandom_range(0, 7) == 0) num2 = {$urandom_range(0, 3), 30'h0};
      req_ready = 1'($urandom_range(0, 1));
      resp_valid = ($urandom_range(0, 3) == 0);
      resp_result = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/posit_pio_bridge.md
POSIT_PIO_BRIDGE -- requirements
Module: posit_pio_bridge

Interface
REQ-001 The block SHALL have parameter NBITS, default 32, giving the posit word width.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4: the number of cycles both operands must be unchanged before an operation issues.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: the maximum number of cycles spent in WAIT.
REQ-004 clock  in  1  single clock; one clock, all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 num1  in  NBITS  operand A from the HPS PIO export.
REQ-007 num2  in  NBITS  operand B from the HPS PIO export.
REQ-008 result  out  NBITS  registered result, to the HPS PIO result export.
REQ-009 req_valid  out  1  operation request to the posit core.
REQ-010 req_ready  in  1  the posit core accepts the request.
REQ-011 req_num1, req_num2  out  NBITS each  operands sent with the request.
REQ-012 resp_valid  in  1  single-cycle pulse from the core: result is valid.
REQ-013 resp_result  in  NBITS  result from the core.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done_count  out  16  count of completed operations.
REQ-016 timeout_err  out  1  sticky flag: a response timed out.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, SETTLE, ISSUE and WAIT.
REQ-018 IDLE: when {num1,num2} differs from the last issued pair {last1,last2}, the block SHALL capture the pair into snap1/snap2, load the settle counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-019 SETTLE: if {num1,num2} differs from the snapshot, the block SHALL recapture the snapshot, reload the counter and stay in SETTLE.
REQ-020 SETTLE: when the counter is 0 and the inputs equal the snapshot, the block SHALL go to ISSUE; otherwise it SHALL decrement the counter.
REQ-021 ISSUE: req_valid SHALL be 1 and req_num1/req_num2 SHALL equal snap1/snap2, held stable until req_ready.
REQ-022 ISSUE: on req_valid and req_ready in the same cycle, the block SHALL set last1/last2 to snap1/snap2, clear the timeout counter and go to WAIT.
REQ-023 WAIT: on resp_valid, result SHALL take resp_result on the next edge, done_count SHALL increment (0xFFFF wraps to 0) and the FSM SHALL go to IDLE.
REQ-024 WAIT: if the timeout counter reaches TIMEOUT_CYCLES-1 with no resp_valid, result SHALL become NaR (1 followed by NBITS-1 zeros, 0x80000000), timeout_err SHALL be set, done_count SHALL be unchanged and the FSM SHALL go to IDLE.
REQ-025 If resp_valid and timeout occur in the same cycle, resp_valid SHALL win.
REQ-026 In IDLE, SETTLE and ISSUE, resp_valid SHALL be ignored.
REQ-027 Operand changes during ISSUE or WAIT SHALL NOT alter the request in flight; on return to IDLE, a difference from last1/last2 SHALL start a new SETTLE.
REQ-028 req_valid SHALL be 0 outside ISSUE, and req_num1/req_num2 SHALL hold snap1/snap2 in all states.
REQ-029 result SHALL change only on the WAIT exit edge.
REQ-030 Minimum latency from a stable operand change to req_valid SHALL be SETTLE_CYCLES+1 cycles.

Reset
REQ-031 On reset, the FSM SHALL go to IDLE and result, snap1, snap2, last1, last2, the settle counter, the timeout counter, done_count and timeout_err SHALL all become 0.
REQ-032 Because last1/last2 are 0 after reset, operand inputs of 0 at reset release SHALL start no operation.
REQ-033 Reset asserted mid-operation SHALL abandon the request, and a later resp_valid for it SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the state enum, the NaR constant function of NBITS, and the default parameter values.
REQ-035 The settle and timeout logic SHALL use one reusable sub-module, posit_pio_down_counter, providing load, decrement and zero flag.

Verification
REQ-036 Reset, num1=0x40000000, num2=0x40000000, core answers 0x48000000 after 3 cycles -> req_valid 5 cycles after the change; result=0x48000000; done_count=1; busy low afterwards.
REQ-037 num1 changes at cycle 0, num2 at cycle 2 -> exactly one request, carrying both new values, issued SETTLE_CYCLES+1 cycles after cycle 2.
REQ-038 req_ready held low for 10 cycles while operands change -> req_valid and req_num* stay stable; the single accept moves the FSM to WAIT.
REQ-039 No resp_valid for 1024 cycles -> result=0x80000000, timeout_err=1 (remains set on later successes), done_count unchanged.
REQ-040 Operands change during WAIT -> the first result matches the old operands, then a second operation issues automatically; done_count=2.
REQ-041 Reset pulsed in WAIT, then a stray resp_valid -> result stays 0 and done_count=0.
